// File: rtl/imem_pkg.sv
// ============================================================================
// Module      : imem_pkg
// Description : Shared types and helpers for the instruction memory fetch unit
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_pkg;

  typedef enum logic [0:0] {
    IMEM_INIT = 1'b0,
    IMEM_RUN  = 1'b1
  } imem_state_t;

  localparam int IMEM_INIT_MUL_DEFAULT = 3;

  function automatic int imem_idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_array.sv
// ============================================================================
// Module      : imem_array
// Description : DEPTH x DATA_WIDTH storage, one synchronous read port and one
//               write port; a read and write to the same word returns old data
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_array
  import imem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 128,
  parameter int IDX_W      = imem_idx_w(DEPTH)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  // Storage has no reset; the init sweep in the parent defines its contents.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_idx];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/imem_fetch_unit.sv
// ============================================================================
// Module      : imem_fetch_unit
// Description : Clocked instruction memory with valid/ready fetch port,
//               program-load port and post-reset init sweep.
//               Optional macro IMEM_BOUNDS_CHECK_EN enables address faults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int INIT_MUL   = IMEM_INIT_MUL_DEFAULT
) (
  input  logic                  Clk,
  input  logic                  Reset,
  output logic                  init_done,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data
);

  localparam int IDX_W = imem_idx_w(DEPTH);

  imem_state_t           state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;

  logic                  req_fire;
  logic                  req_fault, ld_fault;
  logic [IDX_W-1:0]      req_idx, ld_idx;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  unused_addr;

  assign req_idx = req_addr[IDX_W+1:2];
  assign ld_idx  = ld_addr[IDX_W+1:2];

`ifdef IMEM_BOUNDS_CHECK_EN
  assign req_fault = (req_addr[1:0] != 2'b00) || ((req_addr >> (IDX_W + 2)) != '0);
  assign ld_fault  = (ld_addr[1:0] != 2'b00)  || ((ld_addr  >> (IDX_W + 2)) != '0);
`else
  assign req_fault = 1'b0;
  assign ld_fault  = 1'b0;
`endif

  // Byte-select and upper bits are intentionally dropped in the wrap build.
  assign unused_addr = &{1'b0, req_addr, ld_addr};

  assign req_ready = (state_q == IMEM_RUN) && (!resp_valid_q || resp_ready);
  assign req_fire  = req_valid && req_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    wr_en        = 1'b0;
    wr_idx       = ld_idx;
    wr_data      = ld_data;

    case (state_q)
      IMEM_INIT: begin
        wr_en   = 1'b1;
        wr_idx  = cnt_q;
        wr_data = DATA_WIDTH'(cnt_q) * DATA_WIDTH'(INIT_MUL);
        cnt_d   = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = IMEM_RUN;
        end
      end
      IMEM_RUN: begin
        wr_en = ld_en && !ld_fault;
      end
      default: begin
        state_d = IMEM_INIT;
      end
    endcase

    if (req_fire) begin
      resp_valid_d = 1'b1;
      resp_err_d   = req_fault;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IMEM_INIT;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  imem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .Clk     (Clk),
    .Reset   (Reset),
    .rd_en   (req_fire),
    .rd_idx  (req_idx),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data)
  );

  assign init_done  = (state_q == IMEM_RUN);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_data  = resp_err_q ? '0 : rd_data;

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch_unit.sv
// ============================================================================
// Module      : tb_imem_fetch_unit
// Description : Self-checking bench for imem_fetch_unit (builds with or
//               without IMEM_BOUNDS_CHECK_EN)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_fetch_unit;

  localparam int DW    = 32;
  localparam int DEPTH = 128;
  localparam int AW    = 32;
  localparam int MUL   = 3;

  logic          Clk        = 1'b0;
  logic          Reset      = 1'b0;
  logic          req_valid  = 1'b0;
  logic [AW-1:0] req_addr   = '0;
  logic          resp_ready = 1'b0;
  logic          ld_en      = 1'b0;
  logic [AW-1:0] ld_addr    = '0;
  logic [DW-1:0] ld_data    = '0;
  logic          init_done, req_ready, resp_valid, resp_err;
  logic [DW-1:0] resp_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 Clk = ~Clk;

  imem_fetch_unit #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .INIT_MUL   (MUL)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .init_done  (init_done),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: memory image, sweep progress and the one-slot response.
  logic [31:0] m_mem [DEPTH];
  int          m_cnt  = 0;
  bit          m_rv   = 1'b0;
  bit          m_err  = 1'b0;
  logic [31:0] m_data = '0;

  function automatic bit m_fault(input logic [31:0] a);
`ifdef IMEM_BOUNDS_CHECK_EN
    return (a[1:0] != 2'b00) || ((a >> ($clog2(DEPTH) + 2)) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_cnt  = 0;
      m_rv   = 1'b0;
      m_err  = 1'b0;
      m_data = '0;
    end else begin
      bit          run;
      bit          acc;
      logic [31:0] old;
      run = (m_cnt == DEPTH);
      acc = run && req_valid && (!m_rv || resp_ready);
      old = '0;
      if (acc) old = m_mem[m_idx(req_addr)];
      if (!run) begin
        m_mem[m_cnt] = m_cnt * MUL;
        m_cnt++;
      end else if (ld_en && !m_fault(ld_addr)) begin
        m_mem[m_idx(ld_addr)] = ld_data;
      end
      if (acc) begin
        m_rv   = 1'b1;
        m_err  = m_fault(req_addr);
        m_data = m_err ? 32'h0 : old;
      end else if (resp_ready) begin
        m_rv = 1'b0;
      end
    end
  end

  always @(negedge Clk) begin
    chk("cyc_init_done",  init_done,  m_cnt == DEPTH);
    chk("cyc_req_ready",  req_ready,  (m_cnt == DEPTH) && (!m_rv || resp_ready));
    chk("cyc_resp_valid", resp_valid, m_rv);
    chk("cyc_resp_data",  resp_data,  m_data);
    chk("cyc_resp_err",   resp_err,   m_err);
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic issue(input logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    tick();
  endtask

  task automatic idle();
    req_valid = 1'b0;
    tick();
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_init_done"},  init_done,  0);
    chk({tag, "_req_ready"},  req_ready,  0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_data"},  resp_data,  0);
    chk({tag, "_resp_err"},   resp_err,   0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1 Reset = 1'b1;
    #1 chk_reset_outputs("por");
    repeat (2) @(posedge Clk);
    #2 Reset = 1'b0;
    wait_init(n);
    chk("init_cycles", n, 128);

    // Back-to-back fetches
    resp_ready = 1'b1;
    issue(32'h0);   chk("fetch_0x0",   resp_data, 0);
    issue(32'h4);   chk("fetch_0x4",   resp_data, 3);
    issue(32'h1FC); chk("fetch_0x1fc", resp_data, 381);
    chk("fetch_valid", resp_valid, 1);
    idle();

    // Back-pressure
    resp_ready = 1'b0;
    issue(32'h8);
    chk("hold_first", resp_data, 6);
    req_addr = 32'hC;
    for (int i = 0; i < 3; i++) begin
      chk("hold_ready", req_ready, 0);
      chk("hold_data",  resp_data, 6);
      tick();
    end
    resp_ready = 1'b1;
    #1 chk("resume_ready", req_ready, 1);
    tick();
    chk("after_hold", resp_data, 9);
    idle();
    chk("drained", resp_valid, 0);

    // Same-cycle load and fetch: read-before-write
    ld_en   = 1'b1;
    ld_addr = 32'h10;
    ld_data = 32'hDEADBEEF;
    issue(32'h10);
    ld_en = 1'b0;
    chk("rbw_old", resp_data, 12);
    issue(32'h10);
    chk("rbw_new", resp_data, 32'hDEADBEEF);
    idle();

    // Out-of-range and misaligned addresses
    issue(32'h200);
`ifdef IMEM_BOUNDS_CHECK_EN
    chk("oob_err", resp_err, 1);  chk("oob_data", resp_data, 0);
`else
    chk("wrap_err", resp_err, 0); chk("wrap_data", resp_data, 0);
`endif
    issue(32'h6);
`ifdef IMEM_BOUNDS_CHECK_EN
    chk("mis_err", resp_err, 1);  chk("mis_data", resp_data, 0);
`else
    chk("mis_err", resp_err, 0);  chk("mis_data", resp_data, 3);
`endif
    idle();

    // Reset mid-sweep at counter 50
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    repeat (50) @(posedge Clk);
    #2 Reset = 1'b1;
    #1 chk_reset_outputs("midsweep");
    tick();
    Reset = 1'b0;
    wait_init(n);
    chk("init_cycles_restart", n, 128);

    // Load at 0x0, leave a response pending, then reset
    ld_en   = 1'b1;
    ld_addr = 32'h0;
    ld_data = 32'h34040000;
    tick();
    ld_en      = 1'b0;
    resp_ready = 1'b0;
    issue(32'h4);
    chk("pending_valid", resp_valid, 1);
    req_valid = 1'b0;
    Reset     = 1'b1;
    #1 chk_reset_outputs("pending");
    resp_ready = 1'b1;
    tick();
    Reset = 1'b0;
    wait_init(n);
    chk("init_cycles_after_load", n, 128);
    issue(32'h0);
    chk("reload_cleared", resp_data, 0);
    idle();
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_fetch_unit.md
# imem_fetch_unit

Parametrised, clocked instruction memory with a valid/ready fetch port, a program-load write port and a post-reset initialisation sweep. It sits between the fetch stage (PC side) and the instruction register, replacing the fixed 128-word combinational instruction memory. It adds registered reads, back-pressure, and run-time program loading.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction word width.
- DEPTH, 128, number of words; must be a power of two, at least 2.
- ADDR_WIDTH, 32, byte-address width of the fetch and load ports.
- INIT_MUL, 3, initial pattern: after the sweep, mem[i] = i*INIT_MUL, truncated to DATA_WIDTH.

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- init_done  out  1  high once the init sweep has completed.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  fetch request accepted when req_valid && req_ready.
- req_addr  in  ADDR_WIDTH  fetch byte address.
- resp_valid  out  1  response holds a fetched word.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  DATA_WIDTH  fetched instruction.
- resp_err  out  1  address fault (only with IMEM_BOUNDS_CHECK_EN).
- ld_en  in  1  program-load write strobe.
- ld_addr  in  ADDR_WIDTH  load byte address.
- ld_data  in  DATA_WIDTH  load data.

## Operation
- Word index is IDX = addr[IDX_W+1:2], with IDX_W = $clog2(DEPTH). Bits [1:0] select a byte and are ignored for indexing.
- FSM states:
  - INIT:
    - Entered on Reset.
    - An internal counter writes mem[cnt] = cnt*INIT_MUL, one word per cycle, for cnt = 0..DEPTH-1.
    - The FSM moves to RUN in the cycle after the write to DEPTH-1.
    - req_ready = 0. ld_en is ignored.
  - RUN:
    - Serves fetches and loads. There is no exit except Reset.
- Fetch handshake:
  - req_ready = (state==RUN) && (!resp_valid || resp_ready).
  - On acceptance, the response register captures mem[IDX] and sets resp_valid.
  - resp_valid clears on a resp_ready handshake with no new request accepted.
  - While resp_valid && !resp_ready, resp_data and resp_err hold stable.
- Load:
  - In RUN, ld_en writes ld_data to mem[IDX(ld_addr)] at the clock edge. No handshake; it always succeeds.
  - A load in RUN to an out-of-range address (with IMEM_BOUNDS_CHECK_EN) is dropped.
- Fetch and load to the same word in the same cycle: read-before-write. The response returns the old word, and the next fetch sees the new one.
- Reset mid-operation:
  - Drops any pending response.
  - Restarts the sweep from 0, overwriting loaded program contents.

## Timing
- Reset values: init_done=0, req_ready=0, resp_valid=0, resp_data=0, resp_err=0, FSM=INIT, counter=0.
- Init sweep takes exactly DEPTH cycles after Reset deasserts. init_done rises on cycle DEPTH, and req_ready can assert in that same cycle.
- Fetch latency is 1 cycle: a request accepted at edge N gives resp_valid high after edge N. Data is registered, and there is no combinational path from req_addr to resp_data.
- Sustained throughput is one fetch per cycle while resp_ready=1.
- A load written at edge N is visible to a fetch accepted at edge N+1.

## Configuration
- IMEM_BOUNDS_CHECK_EN defined:
  - resp_err=1 and resp_data=0 when the fetch address has addr[1:0]!=0 or addr[ADDR_WIDTH-1:IDX_W+2]!=0.
  - Faulting loads are discarded.
- IMEM_BOUNDS_CHECK_EN undefined:
  - Upper address bits are ignored, so the index wraps modulo DEPTH.
  - addr[1:0] are ignored.
  - resp_err is tied to 0.

## Structure
- Shared package imem_pkg holds:
  - FSM state encoding (IMEM_INIT, IMEM_RUN).
  - Default INIT_MUL.
  - A function computing IDX_W.
- One sub-module, imem_array: DEPTH x DATA_WIDTH storage with one synchronous read port and one write port, read-before-write. The sweep writer and the load port are muxed in front of its write port.
- The top level holds the FSM, the init counter, the handshake logic and the response register.

## Test plan
- Reset, wait for init_done, then fetch addresses 0x0, 0x4, 0x1FC with resp_ready=1 → resp_data 0, 3, 381 on consecutive cycles. init_done rises exactly 128 cycles after Reset falls.
- Hold resp_ready=0 after one fetch of 0x8 (data 6) while req_valid stays high → req_ready=0 and resp_data stays 6 until resp_ready rises. No request is lost or duplicated.
- In the same cycle, ld_en to 0x10 with 0xDEADBEEF and a fetch of 0x10 → response 12. The next fetch of 0x10 returns 0xDEADBEEF.
- With IMEM_BOUNDS_CHECK_EN, fetch 0x200 and 0x6 → resp_err=1 and resp_data=0 for each. Without the macro, 0x200 returns mem[0] = 0.
- Assert Reset mid-sweep (counter=50) and again with resp_valid=1 → all outputs return to reset values, and the sweep restarts and takes the full 128 cycles.
- Load 0x34040000 at 0x0 in RUN, then pulse Reset → a fetch of 0x0 after init_done returns 0.
